// File: rtl/vga_text_pkg.sv
// Shared constants, attribute-word layout and the 16-colour CGA palette for the text renderer.
package vga_text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELL_W = 8;
  localparam int CELL_H = 16;
  localparam int DISP_W = COLS * CELL_W;
  localparam int DISP_H = ROWS * CELL_H;

  localparam int ATTR_CODE_LSB = 0;
  localparam int ATTR_CODE_MSB = 7;
  localparam int ATTR_FG_LSB   = 8;
  localparam int ATTR_FG_MSB   = 11;
  localparam int ATTR_BG_LSB   = 12;
  localparam int ATTR_BG_MSB   = 15;

  // Field order mirrors the character RAM word: [15:12] bg, [11:8] fg, [7:0] code.
  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] code;
  } char_word_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // row*80+col as shift-and-add; 12 bits holds the largest in-range cell (2399).
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [11:0] row_w;
    row_w = {7'b0, row};
    return (row_w << 6) + (row_w << 4) + {5'b0, col};
  endfunction

  function automatic rgb_t cga_colour(input logic [3:0] idx);
    rgb_t c;
    c = 24'h000000;
    case (idx)
      4'd0:  c = 24'h000000;
      4'd1:  c = 24'h0000AA;
      4'd2:  c = 24'h00AA00;
      4'd3:  c = 24'h00AAAA;
      4'd4:  c = 24'hAA0000;
      4'd5:  c = 24'hAA00AA;
      4'd6:  c = 24'hAA5500;
      4'd7:  c = 24'hAAAAAA;
      4'd8:  c = 24'h555555;
      4'd9:  c = 24'h5555FF;
      4'd10: c = 24'h55FF55;
      4'd11: c = 24'h55FFFF;
      4'd12: c = 24'hFF5555;
      4'd13: c = 24'hFF55FF;
      4'd14: c = 24'hFFFF55;
      4'd15: c = 24'hFFFFFF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_text_blink.sv
// Frame counter for the cursor blink; only built when VGA_TEXT_CURSOR_EN is defined.
// Counts falling edges of the registered vertical sync; the cursor shows while the MSB is 0.
`ifdef VGA_TEXT_CURSOR_EN
module vga_text_blink #(
  parameter int BLINK_LOG2 = 5
) (
  input  logic clk_25,
  input  logic rst,
  input  logic vga_vs,
  output logic cursor_on
);

  logic                  vs_q;
  logic [BLINK_LOG2-1:0] frame_cnt;

  // A low pulse of any length counts once: only the 1->0 transition advances the count.
  always_ff @(posedge clk_25) begin
    if (!rst) begin
      vs_q      <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vs_q <= vga_vs;
      if (vs_q && !vga_vs) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign cursor_on = ~frame_cnt[BLINK_LOG2-1];

endmodule
`endif

// File: rtl/vga_text_render.sv
// Character-mode pixel source: x/y in, RGB out exactly 3 clk_25 cycles later.
// Define VGA_TEXT_CURSOR_EN to build the blinking underline cursor and its frame counter.
module vga_text_render
  import vga_text_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active,
  input  logic        vga_vs,
  output logic [11:0] char_addr,
  input  logic [15:0] char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  logic       in_disp;
  logic [6:0] col;
  logic [4:0] row;
  logic       cursor_hit;

  logic [2:0] s0_xl;
  logic [3:0] s0_yl;
  logic       s0_active;
  logic       s0_cursor;

  char_word_t word;
  logic [3:0] s1_fg;
  logic [3:0] s1_bg;
  logic [2:0] s1_xl;
  logic       s1_active;
  logic       s1_cursor;

  logic       pix_bit;
  logic [3:0] colour_idx;
  rgb_t       colour;

  assign col     = x[9:3];
  assign row     = y[8:4];
  assign in_disp = active && (int'(x) < COLS * CELL_W) && (int'(y) < ROWS * CELL_H);

`ifdef VGA_TEXT_CURSOR_EN
  logic cursor_on;

  vga_text_blink #(
    .BLINK_LOG2(BLINK_LOG2)
  ) u_blink (
    .clk_25    (clk_25),
    .rst       (rst),
    .vga_vs    (vga_vs),
    .cursor_on (cursor_on)
  );

  // Visibility is sampled here and travels with the pixel, so a frame edge never splits one.
  assign cursor_hit = cursor_on
                    && (col == cursor_col) && (row == cursor_row)
                    && (y[3:1] == 3'b111)
                    && (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS);
`else
  logic unused_cursor_inputs;
  localparam int unused_blink_log2 = BLINK_LOG2;

  assign unused_cursor_inputs = ^{cursor_col, cursor_row, vga_vs};
  assign cursor_hit           = 1'b0;
`endif

  // Stage 0: cell address to the character RAM; off-screen pixels read cell 0 and go black.
  always_ff @(posedge clk_25) begin
    if (!rst) begin
      char_addr <= '0;
      s0_xl     <= '0;
      s0_yl     <= '0;
      s0_active <= 1'b0;
      s0_cursor <= 1'b0;
    end else begin
      char_addr <= in_disp ? cell_addr(row, col) : 12'd0;
      s0_xl     <= x[2:0];
      s0_yl     <= y[3:0];
      s0_active <= in_disp;
      s0_cursor <= in_disp && cursor_hit;
    end
  end

  assign word = char_data;

  // Stage 1: glyph row address to the font ROM, attribute colours carried alongside.
  always_ff @(posedge clk_25) begin
    if (!rst) begin
      font_addr <= '0;
      s1_fg     <= '0;
      s1_bg     <= '0;
      s1_xl     <= '0;
      s1_active <= 1'b0;
      s1_cursor <= 1'b0;
    end else begin
      font_addr <= {word.code, s0_yl};
      s1_fg     <= word.fg;
      s1_bg     <= word.bg;
      s1_xl     <= s0_xl;
      s1_active <= s0_active;
      s1_cursor <= s0_cursor;
    end
  end

  assign pix_bit    = font_data[3'd7 - s1_xl];
  assign colour_idx = (pix_bit || s1_cursor) ? s1_fg : s1_bg;
  assign colour     = cga_colour(colour_idx);

  // Stage 2: palette lookup, blanked outside the display area.
  always_ff @(posedge clk_25) begin
    if (!rst) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else if (s1_active) begin
      r <= colour.r;
      g <= colour.g;
      b <= colour.b;
    end else begin
      r <= '0;
      g <= '0;
      b <= '0;
    end
  end

endmodule
